register_file_mp: RTL and testbench

REGISTER_FILE_MP -- requirements
Module: register_file_mp

---
 rtl/register_file_mp.sv | 114 +++++++++++
 tb/tb_register_file_mp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/register_file_mp.sv
// Register file with two read ports, one write port, a per-register pending scoreboard and a bulk-clear engine.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module register_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] RdAddr1,
    input  logic [ADDR_W-1:0] RdAddr2,
    output logic [DATA_W-1:0] RdData1,
    output logic [DATA_W-1:0] RdData2,
    output logic              Pending1,
    output logic              Pending2,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              ResvEn,
    input  logic [ADDR_W-1:0] ResvAddr,
    input  logic              ClrReq,
    output logic              ClrBusy,
    output logic              ClrDone
);
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clrState_t;

    clrState_t           state;
    logic [ADDR_W-1:0]   clrIdx;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic                busyQ;
    logic                doneQ;
    logic                wrAcc;
    logic                resvAcc;
    logic                fwd1;
    logic                fwd2;

    function automatic logic isZero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // busyQ is high exactly while the FSM sits in CLEAR, so it doubles as the write/reserve lockout.
    assign wrAcc   = WrEn   && !busyQ && !isZero(WrAddr);
    assign resvAcc = ResvEn && !busyQ && !isZero(ResvAddr);

    // NOTE: the register array takes the async reset because a reset must leave every register reading zero.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            pending <= '0;
            clrIdx  <= '0;
            state   <= IDLE;
            busyQ   <= 1'b0;
            doneQ   <= 1'b0;
        end else begin
            if (wrAcc) begin
                regs[WrAddr]    <= WrData;
                pending[WrAddr] <= 1'b0;
            end
            // NOTE: the later non-blocking assignment wins, so a same-address reservation keeps the bit set.
            if (resvAcc) pending[ResvAddr] <= 1'b1;

            case (state)
                IDLE: begin
                    doneQ <= 1'b0;
                    if (ClrReq) begin
                        state  <= CLEAR;
                        busyQ  <= 1'b1;
                        clrIdx <= '0;
                    end
                end
                CLEAR: begin
                    regs[clrIdx]    <= '0;
                    pending[clrIdx] <= 1'b0;
                    if (clrIdx == LAST_IDX) begin
                        state <= DONE;
                        busyQ <= 1'b0;
                        doneQ <= 1'b1;
                    end else begin
                        clrIdx <= clrIdx + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    doneQ <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busyQ <= 1'b0;
                    doneQ <= 1'b0;
                end
            endcase
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign fwd1 = wrAcc && (WrAddr == RdAddr1) && !(resvAcc && (ResvAddr == WrAddr));
    assign fwd2 = wrAcc && (WrAddr == RdAddr2) && !(resvAcc && (ResvAddr == WrAddr));
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    // Reads are gated by RESET so a write presented during reset cannot leak through the bypass.
    assign RdData1  = (RESET || isZero(RdAddr1)) ? '0 : (fwd1 ? WrData : regs[RdAddr1]);
    assign RdData2  = (RESET || isZero(RdAddr2)) ? '0 : (fwd2 ? WrData : regs[RdAddr2]);
    assign Pending1 = !RESET && !isZero(RdAddr1) && !fwd1 && pending[RdAddr1];
    assign Pending2 = !RESET && !isZero(RdAddr2) && !fwd2 && pending[RdAddr2];
    assign ClrBusy  = busyQ;
    assign ClrDone  = doneQ;
endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed steps, expectations queued on drive and popped on sample.
module tb_register_file_mp;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [ADDR_W-1:0] RdAddr1, RdAddr2, WrAddr, ResvAddr;
    logic [DATA_W-1:0] RdData1, RdData2, WrData;
    logic              Pending1, Pending2, WrEn, ResvEn, ClrReq, ClrBusy, ClrDone;

    always #5 CLK = ~CLK;

    register_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .CLK(CLK), .RESET(RESET),
        .RdAddr1(RdAddr1), .RdAddr2(RdAddr2), .RdData1(RdData1), .RdData2(RdData2),
        .Pending1(Pending1), .Pending2(Pending2),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .ResvEn(ResvEn), .ResvAddr(ResvAddr),
        .ClrReq(ClrReq), .ClrBusy(ClrBusy), .ClrDone(ClrDone)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] expQ[$];
    string       tagQ[$];
    logic [31:0] model [NUM_REGS];

    task automatic push(input string tag, input logic [31:0] e);
        tagQ.push_back(tag);
        expQ.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] e;
        total++;
        if (expQ.size() == 0) begin
            bad++;
            $error("FAIL sb_underflow observed=%h", obs);
            return;
        end
        tag = tagQ.pop_front();
        e   = expQ.pop_front();
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fillRegs(input logic [31:0] base);
        WrEn = 1'b1;
        for (int i = 1; i < NUM_REGS; i++) begin
            WrAddr = ADDR_W'(i);
            WrData = base + 32'(i);
            model[i] = WrData;
            step();
        end
        WrEn = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            RdAddr1 = ADDR_W'(i);
            RdAddr2 = ADDR_W'(i);
            #1;
            push({tag, "_data"}, 32'h0);
            push({tag, "_pend"}, 32'h0);
            check(RdData1);
            check(32'(Pending2));
        end
    endtask

    initial begin
        int n;
        int doneCnt;
        int busyCnt;

        RESET = 1'b1; WrEn = 1'b0; ResvEn = 1'b0; ClrReq = 1'b0;
        WrAddr = '0; WrData = '0; ResvAddr = '0; RdAddr1 = '0; RdAddr2 = '0;
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

        // Reset: outputs held low even with a write presented to the read address.
        #2;
        WrEn = 1'b1; WrAddr = 5'd5; WrData = 32'hFFFF_0000; RdAddr1 = 5'd5; RdAddr2 = 5'd5;
        step();
        push("rst_busy", 32'h0); check(32'(ClrBusy));
        push("rst_done", 32'h0); check(32'(ClrDone));
        push("rst_rd1", 32'h0);  check(RdData1);
        push("rst_rd2", 32'h0);  check(RdData2);
        push("rst_pend1", 32'h0); check(32'(Pending1));
        WrEn = 1'b0;
        RESET = 1'b0;
        step();

        // Basic write, visible on both ports after the edge.
        WrEn = 1'b1; WrAddr = 5'd5; WrData = 32'hDEAD_BEEF;
        step();
        WrEn = 1'b0; model[5] = 32'hDEAD_BEEF;
        #1;
        push("x5_rd1", model[5]); check(RdData1);
        push("x5_rd2", model[5]); check(RdData2);

        // Register 0 ignores writes and reservations.
        WrEn = 1'b1; WrAddr = 5'd0; WrData = 32'h1234_5678; ResvEn = 1'b1; ResvAddr = 5'd0;
        step();
        WrEn = 1'b0; ResvEn = 1'b0; RdAddr1 = 5'd0;
        #1;
        push("x0_data", 32'h0); check(RdData1);
        push("x0_pend", 32'h0); check(32'(Pending1));

        // Reservation sets pending; a write clears it; same-cycle reservation wins.
        ResvEn = 1'b1; ResvAddr = 5'd7;
        step();
        ResvEn = 1'b0; RdAddr1 = 5'd7;
        #1;
        push("x7_resv_pend", 32'h1); check(32'(Pending1));
        WrEn = 1'b1; WrAddr = 5'd7; WrData = 32'h55;
        step();
        WrEn = 1'b0; model[7] = 32'h55;
        #1;
        push("x7_wr_pend", 32'h0); check(32'(Pending1));
        push("x7_wr_data", model[7]); check(RdData1);
        WrEn = 1'b1; WrAddr = 5'd7; WrData = 32'h55; ResvEn = 1'b1; ResvAddr = 5'd7;
        step();
        WrEn = 1'b1; WrAddr = 5'd8; WrData = 32'h99; ResvEn = 1'b1; ResvAddr = 5'd8;
        #1;
        push("x7_both_data", 32'h55); check(RdData1);
        push("x7_both_pend", 32'h1); check(32'(Pending1));
        step();
        WrEn = 1'b0; ResvEn = 1'b0; model[8] = 32'h99; RdAddr2 = 5'd8;
        #1;
        push("x8_both_data", model[8]); check(RdData2);
        push("x8_both_pend", 32'h1); check(32'(Pending2));

        // Same-cycle read of a register being written.
        WrEn = 1'b1; WrAddr = 5'd3; WrData = 32'h1111_1111;
        step();
        model[3] = 32'h1111_1111;
        WrData = 32'hA5A5_A5A5; RdAddr1 = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        push("x3_same_cycle", 32'hA5A5_A5A5);
`else
        push("x3_same_cycle", model[3]);
`endif
        check(RdData1);
        step();
        WrEn = 1'b0; model[3] = 32'hA5A5_A5A5;
        #1;
        push("x3_after_edge", model[3]); check(RdData1);

        // Bulk clear with writes and reservations attempted throughout.
        fillRegs(32'hC0DE_0000);
        ResvEn = 1'b1; ResvAddr = 5'd9;
        step();
        ResvEn = 1'b0; RdAddr1 = 5'd31; RdAddr2 = 5'd9;
        #1;
        push("fill_x31", model[31]); check(RdData1);
        push("fill_x9_pend", 32'h1); check(32'(Pending2));
        ClrReq = 1'b1;
        step();
        ClrReq = 1'b0;
        WrEn = 1'b1; WrAddr = 5'd2; WrData = 32'hFFFF_FFFF;
        ResvEn = 1'b1; ResvAddr = 5'd1;
        n = 0;
        while (ClrBusy === 1'b1 && n < 100) begin
            n++;
            if (n == 5) begin
                RdAddr1 = 5'd2; RdAddr2 = 5'd20;
                #1;
                push("mid_clear_done_idx", 32'h0); check(RdData1);
                push("mid_clear_old_idx", model[20]); check(RdData2);
            end
            step();
        end
        WrEn = 1'b0; ResvEn = 1'b0;
        push("busy_cycles", 32'd32); check(32'(n));
        push("done_pulse", 32'h1); check(32'(ClrDone));
        step();
        push("done_drop", 32'h0); check(32'(ClrDone));
        push("busy_idle", 32'h0); check(32'(ClrBusy));
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        checkAllZero("after_clear");

        // Reset in the middle of a clear.
        fillRegs(32'hBEEF_0000);
        ClrReq = 1'b1;
        step();
        ClrReq = 1'b0;
        for (int i = 0; i < 10; i++) step();
        RdAddr1 = 5'd31; RdAddr2 = 5'd15;
        RESET = 1'b1;
        #1;
        push("abort_busy", 32'h0); check(32'(ClrBusy));
        push("abort_rd1", 32'h0); check(RdData1);
        step();
        RESET = 1'b0;
        doneCnt = 0;
        busyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ClrDone === 1'b1) doneCnt++;
            if (ClrBusy === 1'b1) busyCnt++;
        end
        push("abort_no_done", 32'h0); check(32'(doneCnt));
        push("abort_idle", 32'h0); check(32'(busyCnt));
        checkAllZero("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
